sdram_port_a_arbiter: RTL and testbench

- Shares the SDRAM controller's single time-slotted host port (port A) between two requesters: port 0 (CPU) and port 1 (DMA/cassette loader).
- The host port has no handshake. This block presents each request with stable address and data for a fixed cycle window that spans at least one full controller slot, then returns read data with a one-cycle ack pulse.
- Arbitration between the two requesters is round-robin.

---
 rtl/sdram_port_a_arbiter.sv | 132 +++++++++++++
 tb/tb_sdram_port_a_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_a_arbiter.sv
// Round-robin arbiter that shares the SDRAM controller's handshake-less host port A
// between a CPU port (0) and a DMA/cassette port (1), holding each request for a fixed window.
module sdram_port_a_arbiter #(
  parameter int SETUP_CYCLES  = 8,
  parameter int ACCESS_CYCLES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [21:0] addr0,
  input  logic [21:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [21:0] mem_address,
  output logic        mem_write,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [4:0] SETUP_LOAD  = 5'(SETUP_CYCLES - 1);
  localparam logic [4:0] ACCESS_LOAD = 5'(ACCESS_CYCLES - 1);

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        grant_q;
  logic        grant_d;
  logic        last_grant_q;
  logic        we_hold_q;
  logic [21:0] mem_address_q;
  logic        mem_write_q;
  logic [15:0] mem_data_out_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [15:0] rdata0_q;
  logic [15:0] rdata1_q;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    grant_d = req1;
    if (req0 && req1) begin
      grant_d = ~last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 5'd0;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      we_hold_q      <= 1'b0;
      mem_address_q  <= 22'd0;
      mem_write_q    <= 1'b0;
      mem_data_out_q <= 16'd0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      rdata0_q       <= 16'd0;
      rdata1_q       <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          mem_write_q <= 1'b0;
          ack0_q      <= 1'b0;
          ack1_q      <= 1'b0;
          if (req0 || req1) begin
            grant_q        <= grant_d;
            mem_address_q  <= grant_d ? addr1 : addr0;
            mem_data_out_q <= grant_d ? wdata1 : wdata0;
            we_hold_q      <= grant_d ? we1 : we0;
            cnt_q          <= SETUP_LOAD;
            state_q        <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 5'd0) begin
            cnt_q       <= ACCESS_LOAD;
            mem_write_q <= we_hold_q;
            state_q     <= ACCESS;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ACCESS: begin
          // Read data is sampled at the very end of the window, after any refresh delay.
          if (cnt_q == 5'd0) begin
            mem_write_q <= 1'b0;
            if (!we_hold_q) begin
              if (grant_q) begin
                rdata1_q <= mem_data_in;
              end else begin
                rdata0_q <= mem_data_in;
              end
            end
            if (grant_q) begin
              ack1_q <= 1'b1;
            end else begin
              ack0_q <= 1'b1;
            end
            last_grant_q <= grant_q;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_address  = mem_address_q;
  assign mem_write    = mem_write_q;
  assign mem_data_out = mem_data_out_q;
  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;

endmodule

// File: tb/tb_sdram_port_a_arbiter.sv
// Bench for sdram_port_a_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized two-port traffic.
module tb_sdram_port_a_arbiter;
  localparam int S = 8;
  localparam int A = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [21:0] addr0 = 22'd0, addr1 = 22'd0;
  logic [15:0] wdata0 = 16'd0, wdata1 = 16'd0, mem_data_in = 16'd0;
  logic        ack0, ack1, mem_write;
  logic [15:0] rdata0, rdata1, mem_data_out;
  logic [21:0] mem_address;

  int checks = 0;
  int failures = 0;
  int gap[2];

  always #5 clk = ~clk;

  sdram_port_a_arbiter #(.SETUP_CYCLES(S), .ACCESS_CYCLES(A)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Controller memory driven by the DUT; the reference memory is driven by the model.
  logic [15:0] ctrl_mem [logic [21:0]];
  logic [15:0] ref_mem  [logic [21:0]];

  function automatic logic [15:0] dflt(input logic [21:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (mem_write === 1'b1) ctrl_mem[mem_address] = mem_data_out;
  end

  always @(negedge clk) begin
    mem_data_in = ctrl_mem.exists(mem_address) ? ctrl_mem[mem_address] : dflt(mem_address);
  end

  // Reference model: one transaction at a time, outputs derived from edges since grant.
  bit          m_busy = 1'b0, m_port = 1'b0, m_last = 1'b1, m_we = 1'b0;
  int          m_phase = 0;
  logic [21:0] m_addr = 22'd0;
  logic [15:0] m_dout = 16'd0, m_rd0 = 16'd0, m_rd1 = 16'd0;
  bit          m_wr = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0;

  always @(posedge clk) begin
    if (m_wr) ref_mem[m_addr] = m_dout;
    if (reset) begin
      m_busy = 0; m_phase = 0; m_last = 1; m_port = 0; m_we = 0;
      m_addr = 22'd0; m_dout = 16'd0; m_wr = 0; m_ack0 = 0; m_ack1 = 0;
      m_rd0 = 16'd0; m_rd1 = 16'd0;
    end else if (!m_busy) begin
      m_wr = 0; m_ack0 = 0; m_ack1 = 0;
      if (req0 || req1) begin
        m_port  = (req0 && req1) ? !m_last : req1;
        m_busy  = 1;
        m_phase = 0;
        m_addr  = m_port ? addr1 : addr0;
        m_dout  = m_port ? wdata1 : wdata0;
        m_we    = m_port ? we1 : we0;
      end
    end else begin
      m_phase++;
      m_wr = (m_phase >= S && m_phase < S + A) ? m_we : 1'b0;
      if (m_phase == S + A) begin
        if (m_port) m_ack1 = 1; else m_ack0 = 1;
        if (!m_we) begin
          if (m_port) m_rd1 = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
          else        m_rd0 = ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr);
        end
        m_last = m_port;
      end else if (m_phase == S + A + 1) begin
        m_ack0 = 0; m_ack1 = 0; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_mem_address", mem_address, m_addr);
    chk("model_mem_write", mem_write, m_wr);
    chk("model_mem_data_out", mem_data_out, m_dout);
    chk("model_ack0", ack0, m_ack0);
    chk("model_ack1", ack1, m_ack1);
    chk("model_rdata0", rdata0, m_rd0);
    chk("model_rdata1", rdata1, m_rd1);
    chk("ack_overlap", ack0 & ack1, 1'b0);
  end

  task automatic set_req(input bit p, input logic v);
    if (p) req1 = v; else req0 = v;
  endtask

  task automatic new_payload(input bit p);
    logic [21:0] a;
    a = ($urandom_range(3) == 0) ? 22'($urandom) : 22'(22'h0A0000 + $urandom_range(7));
    if (p) begin
      we1 = ($urandom_range(1) == 1); addr1 = a; wdata1 = 16'($urandom);
    end else begin
      we0 = ($urandom_range(1) == 1); addr0 = a; wdata0 = 16'($urandom);
    end
  endtask

  task automatic step_port(input bit p);
    logic r, k;
    r = p ? req1 : req0;
    k = p ? ack1 : ack0;
    if (r) begin
      if (k === 1'b1) begin
        if ($urandom_range(1) == 1) new_payload(p);
        else begin set_req(p, 1'b0); gap[p] = int'($urandom_range(6)); end
      end else if ($urandom_range(49) == 0) begin
        new_payload(p);
      end
    end else if (gap[p] > 0) begin
      gap[p]--;
    end else begin
      set_req(p, 1'b1);
      new_payload(p);
    end
  endtask

  // Issues one request on an idle arbiter and measures the window relative to the grant edge.
  task automatic run_txn(input bit p, input logic we, input logic [21:0] a, input logic [15:0] d,
                         input int poke_at, output int ack_idx, output int wr_first,
                         output int wr_cnt, output bit addr_ok, output bit data_ok,
                         output bit other_ack);
    ack_idx = -1; wr_first = -1; wr_cnt = 0; addr_ok = 1; data_ok = 1; other_ack = 0;
    if (p) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    @(posedge clk);
    for (int idx = 0; idx < 60; idx++) begin
      @(negedge clk);
      if (idx == poke_at) begin
        if (p) begin addr1 = ~a; wdata1 = ~d; end
        else   begin addr0 = ~a; wdata0 = ~d; end
      end
      if (mem_address !== a) addr_ok = 0;
      if (mem_data_out !== d) data_ok = 0;
      if (mem_write === 1'b1) begin
        if (wr_first < 0) wr_first = idx;
        wr_cnt++;
      end
      if ((p ? ack0 : ack1) === 1'b1) other_ack = 1;
      if ((p ? ack1 : ack0) === 1'b1) begin
        ack_idx = idx;
        break;
      end
    end
    set_req(p, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai, wf, wc, np, c, n_other;
    bit ao, dok, oa;
    int ports[4];
    int times[4];

    ctrl_mem[22'h012345] = 16'hBEEF;
    ref_mem[22'h012345]  = 16'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_mem_address", mem_address, 22'd0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_data_out", mem_data_out, 16'd0);
    chk("rst_acks", {ack1, ack0}, 2'b00);
    chk("rst_rdata", {rdata1, rdata0}, 32'd0);
    reset = 0;

    // Port 0 read
    run_txn(1'b0, 1'b0, 22'h012345, 16'h0000, -1, ai, wf, wc, ao, dok, oa);
    chk("p0_read_ack_latency", ai, 28);
    chk("p0_read_addr_stable", ao, 1'b1);
    chk("p0_read_no_write", wc, 0);
    chk("p0_read_rdata", rdata0, 16'hBEEF);
    chk("p0_read_no_ack1", oa, 1'b0);
    chk("p0_read_ack_cleared", ack0, 1'b0);

    // Port 1 write
    run_txn(1'b1, 1'b1, 22'h3FFF00, 16'hA55A, -1, ai, wf, wc, ao, dok, oa);
    chk("p1_write_ack_latency", ai, 28);
    chk("p1_write_first_we", wf, 8);
    chk("p1_write_we_cycles", wc, 20);
    chk("p1_write_data_stable", dok, 1'b1);
    chk("p1_write_mem", ctrl_mem.exists(22'h3FFF00) ? ctrl_mem[22'h3FFF00] : 16'hxxxx, 16'hA55A);
    chk("p1_write_rdata_kept", rdata1, 16'h0000);

    // Payload changes during SETUP are ignored
    run_txn(1'b0, 1'b1, 22'h000111, 16'h1234, 2, ai, wf, wc, ao, dok, oa);
    chk("poke_addr_held", ao, 1'b1);
    chk("poke_data_held", dok, 1'b1);
    chk("poke_mem", ctrl_mem.exists(22'h000111) ? ctrl_mem[22'h000111] : 16'hxxxx, 16'h1234);

    // Both ports requesting from reset release
    reset = 1; req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    addr0 = 22'h000010; addr1 = 22'h000020;
    @(negedge clk);
    reset = 0;
    np = 0; c = 0;
    while (np < 4 && c < 300) begin
      @(negedge clk);
      c++;
      if (ack0 === 1'b1 && np < 4) begin ports[np] = 0; times[np] = c; np++; end
      if (ack1 === 1'b1 && np < 4) begin ports[np] = 1; times[np] = c; np++; end
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("rr_ack_count", np, 4);
    chk("rr_first_ack_time", (np > 0) ? times[0] : -1, 29);
    for (int i = 0; i < np; i++) chk($sformatf("rr_order_%0d", i), ports[i], i % 2);
    for (int i = 1; i < np; i++) chk($sformatf("rr_period_%0d", i), times[i] - times[i-1], 30);

    // Port 0 back to back, port 1 idle
    req0 = 1; we0 = 0; addr0 = 22'h0A0003;
    np = 0; c = 0; n_other = 0;
    while (np < 3 && c < 300) begin
      @(negedge clk);
      c++;
      if (ack1 === 1'b1) n_other++;
      if (ack0 === 1'b1) begin ports[np] = 0; times[np] = c; np++; end
    end
    req0 = 0;
    @(negedge clk);
    chk("b2b_ack_count", np, 3);
    chk("b2b_no_ack1", n_other, 0);
    chk("b2b_first_ack_time", (np > 0) ? times[0] : -1, 29);
    for (int i = 1; i < np; i++) chk($sformatf("b2b_period_%0d", i), times[i] - times[i-1], 30);

    // Reset in the 12th cycle of a write access, then re-grant
    req1 = 1; we1 = 1; addr1 = 22'h155555; wdata1 = 16'hC3C3;
    @(posedge clk);
    wc = 0;
    for (int i = 0; i < 60 && wc < 12; i++) begin
      @(negedge clk);
      if (mem_write === 1'b1) wc++;
    end
    chk("rst_mid_we_cycles", wc, 12);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_write_drop", mem_write, 1'b0);
    chk("rst_mid_no_ack", {ack1, ack0}, 2'b00);
    reset = 0;
    run_txn(1'b1, 1'b1, 22'h155555, 16'hC3C3, -1, ai, wf, wc, ao, dok, oa);
    chk("regrant_ack_latency", ai, 28);
    chk("regrant_first_we", wf, 8);
    chk("regrant_we_cycles", wc, 20);

    // Randomized traffic on both ports with occasional resets
    gap[0] = 0; gap[1] = 3;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      step_port(1'b0);
      step_port(1'b1);
      if (reset) reset = 0;
      else if ($urandom_range(399) == 0) reset = 1;
    end
    req0 = 0; req1 = 0; reset = 0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
